// File: rtl/uart_tx_fifo.sv
// Purpose : buffered UART transmitter, 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Latency : a word pushed into an empty FIFO while idle starts its start bit one edge later.
// Backpres: o_Tx_Ready drops when the FIFO is full; strobes seen while it is low are dropped.
//
// Ports:
//   i_Clock       sole clock, rising edge
//   i_Reset       asynchronous active-high reset; aborts any frame, empties the FIFO
//   i_Tx_DV       write strobe, accepted when o_Tx_Ready = 1
//   i_Tx_Byte     word to send, sampled with i_Tx_DV
//   o_Tx_Ready    registered, high while the FIFO holds fewer than FIFO_DEPTH words
//   o_Tx_Serial   registered serial line, idle high
//   o_Tx_Active   high from start bit through last stop bit
//   o_Tx_Done     one-cycle pulse after the last stop-bit cycle of each frame
//   o_Fifo_Count  words queued, not counting the word on the line
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tx_DV,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNTW-1:0]      fifo_cnt;
    logic [CNTW-1:0]      fifo_cnt_nxt;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_vld;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_par;

    // Ready is the registered "not full" flag, so a strobe while full is
    // ignored even if the transmitter frees a slot in that same cycle.
    assign fifo_push = i_Tx_DV && o_Tx_Ready;
    assign fifo_vld  = (fifo_cnt != '0);
    assign fifo_head = fifo_mem[rd_ptr];

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + CNTW'(1);
            2'b01:   fifo_cnt_nxt = fifo_cnt - CNTW'(1);
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            o_Tx_Ready <= 1'b1;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt   <= fifo_cnt_nxt;
            o_Tx_Ready <= (fifo_cnt_nxt < FULL_CNT);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_Clock) begin
        if (fifo_push) fifo_mem[wr_ptr] <= i_Tx_Byte;
    end

    assign o_Fifo_Count = fifo_cnt;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 clk_last;
    logic                 stop_last;

    assign clk_last  = (clk_cnt == CLK_LAST);
    assign stop_last = (state == ST_STOP) && clk_last && (bit_idx == STOP_LAST);

    // Pop from idle, or on the final stop cycle so the next start bit
    // follows with no idle gap.
    assign fifo_pop = fifo_vld && ((state == ST_IDLE) || stop_last);

    // Parity is taken from the word as it leaves the FIFO, before shifting.
    assign fifo_par = (^fifo_head) ^ (PARITY == 1);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (fifo_vld) begin
                        shift_reg   <= fifo_head;
                        parity_bit  <= fifo_par;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    if (clk_last) begin
                        clk_cnt     <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state       <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                o_Tx_Serial <= parity_bit;
                                state       <= ST_PARITY;
                            end else begin
                                o_Tx_Serial <= 1'b1;
                                state       <= ST_STOP;
                            end
                        end else begin
                            bit_idx     <= bit_idx + 4'd1;
                            o_Tx_Serial <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_PARITY: begin
                    if (clk_last) begin
                        clk_cnt     <= '0;
                        o_Tx_Serial <= 1'b1;
                        state       <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx   <= '0;
                            o_Tx_Done <= 1'b1;
                            if (fifo_vld) begin
                                shift_reg   <= fifo_head;
                                parity_bit  <= fifo_par;
                                o_Tx_Serial <= 1'b0;
                                state       <= ST_START;
                            end else begin
                                o_Tx_Active <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : scoreboard bench for uart_tx_fifo across four frame formats at 4 clocks per bit.
// Latency : expected line patterns are queued at stimulus time and checked bit-cycle by bit-cycle.
// Backpres: FIFO-full drop, push/pop overlap and mid-frame reset are exercised on the 8N1 instance.
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;   // bits[0] is the first bit on the line (start bit)
        int          nbits;
        bit          abort;  // frame is expected to be cut short by reset
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] b0;
    logic [6:0] b1;
    logic [6:0] b2;
    logic [8:0] b3;
    logic [3:0] ser_w;
    logic [3:0] act_w;
    logic [3:0] done_w;
    logic [3:0] rdy_w;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails = 0;
    int   sel = 0;
    int   done_total = 0;
    int   b2b_cnt = 0;
    bit   mon_busy = 1'b0;

    // 8N1
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(b0),
        .o_Tx_Ready(rdy_w[0]), .o_Tx_Serial(ser_w[0]), .o_Tx_Active(act_w[0]),
        .o_Tx_Done(done_w[0]), .o_Fifo_Count(cnt0));
    // 7E2
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(b1),
        .o_Tx_Ready(rdy_w[1]), .o_Tx_Serial(ser_w[1]), .o_Tx_Active(act_w[1]),
        .o_Tx_Done(done_w[1]), .o_Fifo_Count(cnt1));
    // 7O2
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(b2),
        .o_Tx_Ready(rdy_w[2]), .o_Tx_Serial(ser_w[2]), .o_Tx_Active(act_w[2]),
        .o_Tx_Done(done_w[2]), .o_Fifo_Count(cnt2));
    // 9O1
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(b3),
        .o_Tx_Ready(rdy_w[3]), .o_Tx_Serial(ser_w[3]), .o_Tx_Active(act_w[3]),
        .o_Tx_Done(done_w[3]), .o_Fifo_Count(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] bits, input int nbits, input bit abort);
        exp_t e;
        e.bits  = bits;
        e.nbits = nbits;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_time", {31'd0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
    endtask

    // Every Done pulse on the selected instance, whether expected or not.
    always @(negedge clk) begin
        if (!rst && done_w[sel]) done_total <= done_total + 1;
    end

    // Monitor: each start bit pops one expected frame and checks every cycle of it.
    initial begin : monitor
        exp_t        e;
        logic [15:0] got_bits;
        bit          have_edge;
        bit          b2b;
        bit          frame_ok;
        bit          aborted;
        have_edge = 1'b0;
        forever begin
            b2b = have_edge;
            if (!have_edge) @(negedge clk);
            have_edge = 1'b0;
            if (!rst && ser_w[sel] == 1'b0) begin
                mon_busy = 1'b1;
                if (b2b) b2b_cnt++;
                chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e        = exp_q.pop_front();
                    got_bits = '0;
                    frame_ok = 1'b1;
                    aborted  = 1'b0;
                    for (int c = 0; c < e.nbits * 4; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (ser_w[sel] !== e.bits[c / 4]) frame_ok = 1'b0;
                        if (act_w[sel] !== 1'b1) frame_ok = 1'b0;
                        if (c > 0 && done_w[sel] !== 1'b0) frame_ok = 1'b0;
                        got_bits[c / 4] = ser_w[sel];
                    end
                    chk("frame_abort", {31'd0, aborted}, {31'd0, e.abort});
                    if (!aborted) begin
                        chk("frame_bits", {16'd0, got_bits}, {16'd0, e.bits});
                        chk("frame_timing", {31'd0, frame_ok}, 32'd1);
                        @(negedge clk);
                        chk("done_after_last_stop", {31'd0, done_w[sel]}, 32'd1);
                        if (ser_w[sel] == 1'b1)
                            chk("active_drop_at_end", {31'd0, act_w[sel]}, 32'd0);
                        have_edge = 1'b1;
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin : stim
        logic [7:0] fifo_w   [6];
        logic [9:0] fifo_f   [5];
        logic [2:0] fifo_cnt [6];
        logic       fifo_rdy [6];
        int d0, bb0, lows;

        fifo_w   = '{8'h01, 8'h80, 8'hF0, 8'h0F, 8'hC3, 8'hAA};
        fifo_f   = '{10'b1_00000001_0, 10'b1_10000000_0, 10'b1_11110000_0,
                     10'b1_00001111_0, 10'b1_11000011_0};
        fifo_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        fifo_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; dv = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        tick(); tick(); tick();
        chk("rst_serial", {28'd0, ser_w}, 32'hF);
        chk("rst_active", {28'd0, act_w}, 32'h0);
        chk("rst_done",   {28'd0, done_w}, 32'h0);
        chk("rst_ready",  {28'd0, rdy_w}, 32'hF);
        chk("rst_count",  {20'd0, cnt0, cnt1, cnt2, cnt3}, 32'd0);
        rst = 1'b0;
        tick();

        // 8N1 0x55
        sel = 0; d0 = done_total;
        expect_frame(16'(10'b1_01010101_0), 10, 1'b0);
        dv[0] = 1'b1; b0 = 8'h55; tick(); dv[0] = 1'b0;
        chk("push_count", {29'd0, cnt0}, 32'd1);
        chk("push_line_still_idle", {31'd0, ser_w[0]}, 32'd1);
        tick();
        chk("pop_line_low", {31'd0, ser_w[0]}, 32'd0);
        chk("pop_count", {29'd0, cnt0}, 32'd0);
        chk("pop_active", {31'd0, act_w[0]}, 32'd1);
        wait_drain(100);
        chk("8n1_done_pulses", 32'(done_total - d0), 32'd1);

        // 7E2 0x41 -> parity 0
        tick(); sel = 1; d0 = done_total;
        expect_frame(16'(11'b11_0_1000001_0), 11, 1'b0);
        dv[1] = 1'b1; b1 = 7'h41; tick(); dv[1] = 1'b0;
        wait_drain(100);
        chk("7e2_done_pulses", 32'(done_total - d0), 32'd1);

        // 7O2 0x41 -> parity 1
        tick(); sel = 2; d0 = done_total;
        expect_frame(16'(11'b11_1_1000001_0), 11, 1'b0);
        dv[2] = 1'b1; b2 = 7'h41; tick(); dv[2] = 1'b0;
        wait_drain(100);
        chk("7o2_done_pulses", 32'(done_total - d0), 32'd1);

        // 9O1 0x1FF -> parity 0
        tick(); sel = 3; d0 = done_total;
        expect_frame(16'(12'b1_0_111111111_0), 12, 1'b0);
        dv[3] = 1'b1; b3 = 9'h1FF; tick(); dv[3] = 1'b0;
        wait_drain(100);
        chk("9o1_done_pulses", 32'(done_total - d0), 32'd1);

        // FIFO fill: six consecutive pushes, the sixth is dropped
        tick(); sel = 0; d0 = done_total; bb0 = b2b_cnt;
        for (int i = 0; i < 5; i++) expect_frame(16'(fifo_f[i]), 10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            dv[0] = 1'b1; b0 = fifo_w[i]; tick();
            chk($sformatf("fill_count_%0d", i), {29'd0, cnt0}, {29'd0, fifo_cnt[i]});
            chk($sformatf("fill_ready_%0d", i), {31'd0, rdy_w[0]}, {31'd0, fifo_rdy[i]});
        end
        dv[0] = 1'b0;
        wait_drain(300);
        chk("fill_done_pulses", 32'(done_total - d0), 32'd5);
        chk("fill_back_to_back", 32'(b2b_cnt - bb0), 32'd4);
        chk("fill_count_empty", {29'd0, cnt0}, 32'd0);
        chk("fill_ready_back", {31'd0, rdy_w[0]}, 32'd1);

        // Push coinciding with a pop at count 2
        tick(); d0 = done_total; bb0 = b2b_cnt;
        expect_frame(16'(10'b1_10100101_0), 10, 1'b0);
        expect_frame(16'(10'b1_00111100_0), 10, 1'b0);
        expect_frame(16'(10'b1_10000001_0), 10, 1'b0);
        expect_frame(16'(10'b1_01111110_0), 10, 1'b0);
        dv[0] = 1'b1; b0 = 8'hA5; tick();   // edge 1
        b0 = 8'h3C; tick();                 // edge 2: frame A starts
        b0 = 8'h81; tick();                 // edge 3
        dv[0] = 1'b0;
        for (int i = 0; i < 38; i++) tick(); // edges 4..41
        chk("overlap_count_before", {29'd0, cnt0}, 32'd2);
        dv[0] = 1'b1; b0 = 8'h7E; tick();   // edge 42: pop B, push D
        dv[0] = 1'b0;
        chk("overlap_count_after", {29'd0, cnt0}, 32'd2);
        chk("overlap_next_start", {31'd0, ser_w[0]}, 32'd0);
        chk("overlap_done", {31'd0, done_w[0]}, 32'd1);
        wait_drain(300);
        chk("overlap_done_pulses", 32'(done_total - d0), 32'd4);
        chk("overlap_back_to_back", 32'(b2b_cnt - bb0), 32'd3);

        // Reset in the middle of DATA with two words queued
        tick();
        expect_frame(16'(10'b1_00000000_0), 10, 1'b1);
        dv[0] = 1'b1; b0 = 8'h00; tick();   // edge 1
        b0 = 8'h11; tick();                 // edge 2: start bit
        b0 = 8'h22; tick();                 // edge 3
        dv[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick(); // edge 9: inside data bit 0
        chk("pre_reset_count", {29'd0, cnt0}, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_reset_serial", {31'd0, ser_w[0]}, 32'd1);
        chk("mid_reset_active", {31'd0, act_w[0]}, 32'd0);
        chk("mid_reset_done", {31'd0, done_w[0]}, 32'd0);
        chk("mid_reset_count", {29'd0, cnt0}, 32'd0);
        chk("mid_reset_ready", {31'd0, rdy_w[0]}, 32'd1);
        tick(); tick();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ser_w[0] == 1'b0) lows++;
        end
        chk("no_frame_after_reset", 32'(lows), 32'd0);
        chk("abort_entry_consumed", 32'(exp_q.size()), 32'd0);
        chk("post_reset_count", {29'd0, cnt0}, 32'd0);

        // All instances back at rest
        chk("end_ready", {28'd0, rdy_w}, 32'hF);
        chk("end_active", {28'd0, act_w}, 32'h0);
        chk("end_counts", {20'd0, cnt0, cnt1, cnt2, cnt3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, the successor of the fixed 8N1 transmitter used by the debugger link. Configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and an internal FIFO, so the debug controller can queue several words and get back-to-back frames with no idle gap. Sits between the debugger command/response logic and the board TX pin.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit period (≥2); counter width is $clog2(CLKS_PER_BIT).
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: words of buffering, power of two, ≥2.

- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; one word accepted per cycle when o_Tx_Ready = 1.
- i_Tx_Byte  in  DATA_BITS  word to send, sampled with i_Tx_DV.
- o_Tx_Ready  out  1  registered; 1 when FIFO count < FIFO_DEPTH.
- o_Tx_Serial  out  1  registered serial line, idle high.
- o_Tx_Active  out  1  high from start bit through last stop bit.
- o_Tx_Done  out  1  one-cycle pulse at end of each frame.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  words queued (excludes word in flight).

## Operation
- Reset values: o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Fifo_Count = 0; FIFO empty, state IDLE.
- Reset mid-frame aborts the frame; line returns high asynchronously; queued words discarded.
- Push: i_Tx_DV && o_Tx_Ready writes i_Tx_Byte. i_Tx_DV while o_Tx_Ready = 0 is dropped silently, even if a pop happens in the same cycle.
- Simultaneous push and pop: both occur, count unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop head into shift register, o_Tx_Serial <= 0, o_Tx_Active <= 1, go START.
- START: hold 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: LSB first, DATA_BITS bits, CLKS_PER_BIT cycles each; then PARITY if PARITY ≠ 0, else STOP.
- PARITY: even = XOR of data bits; odd = inverted XOR. One bit period.
- STOP: line high for STOP_BITS × CLKS_PER_BIT cycles. On the last cycle, o_Tx_Done <= 1 for one cycle. Then, if FIFO is non-empty, pop and enter START directly with no idle cycle and o_Tx_Active kept at 1. Otherwise enter IDLE with o_Tx_Active <= 0.
- Bit counter wraps only via explicit clear. Clock counter compares against CLKS_PER_BIT-1.

## Timing
- Word pushed at edge N into an empty FIFO while IDLE: popped at edge N+1; o_Tx_Serial low from edge N+1.
- Frame length: exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, from the falling start edge to the next start edge when back-to-back.
- o_Tx_Done is asserted in the cycle following the last stop-bit cycle. It coincides with the next start bit when frames are back-to-back.
- o_Tx_Ready and o_Fifo_Count update on the edge after the push/pop.

## Test plan
- Reset: assert i_Reset mid-DATA with CLKS_PER_BIT = 4 -> o_Tx_Serial = 1 immediately; Active, Done, and Count go to 0; Ready = 1; no further frame after release.
- 8N1, CLKS_PER_BIT = 4, push 0x55 -> line 0,1,0,1,0,1,0,1,0,1 for 4 cycles each (start, LSB-first data, stop); one Done pulse at cycle 40 after the start edge.
- DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, push 0x41 -> start, 1000001 LSB first, parity 0, two stop bits; frame is 44 cycles. Same with PARITY = 1 -> parity bit 1.
- DATA_BITS = 9, PARITY = 1, push 0x1FF -> nine 1s, then parity 0 (nine ones is odd, so odd parity adds 0).
- FIFO_DEPTH = 4, push w0..w5 on 6 consecutive cycles from idle -> w0 popped at edge 2; Ready low after edge 5; w5 dropped. Exactly 5 contiguous frames with no idle gap, 5 Done pulses, Count back to 0.
- Push in the same cycle as a pop at count = 2 -> count stays 2 and word order is preserved on the line.
